// File: rtl/lms_spi_pkg.sv
// Shared constants for the lms_ctr SPI blocks: register map, status/control bit positions, widths.
package lms_spi_pkg;

    localparam int unsigned DATABITS = 8;
    localparam int unsigned CNTBITS  = 3;
    localparam int unsigned BUSBITS  = 16;
    localparam int unsigned ADDRBITS = 3;

    localparam logic [ADDRBITS-1:0] REG_RXDATA  = 3'd0;
    localparam logic [ADDRBITS-1:0] REG_TXDATA  = 3'd1;
    localparam logic [ADDRBITS-1:0] REG_STATUS  = 3'd2;
    localparam logic [ADDRBITS-1:0] REG_CONTROL = 3'd3;
    localparam logic [ADDRBITS-1:0] REG_EOP     = 3'd6;

    localparam int unsigned STAT_EOP  = 9;
    localparam int unsigned STAT_E    = 8;
    localparam int unsigned STAT_RRDY = 7;
    localparam int unsigned STAT_TRDY = 6;
    localparam int unsigned STAT_TMT  = 5;
    localparam int unsigned STAT_TOE  = 4;
    localparam int unsigned STAT_ROE  = 3;

    // Control register holds interrupt enables aligned with status bits 9..3
    localparam logic [BUSBITS-1:0] CTRL_MASK = 16'h03F8;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } spi_state_t;

endpackage

// File: rtl/lms_spi_sync_edge.sv
// N-stage synchronizer for an asynchronous pin with registered-history rise/fall pulses.
module lms_spi_sync_edge #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic rise_c,
    output logic fall_c
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= {STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], async_in};
            prev  <= chain[STAGES-1];
        end
    end

    assign rise_c = chain[STAGES-1] & ~prev;
    assign fall_c = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/lms_ctr_fpga_spi_slave.sv
// SPI mode-0 slave with CPU holding-register port. Optional EOP detection and register 6
// are built when LMS_SPI_SLAVE_EOP_EN is defined.
module lms_ctr_fpga_spi_slave
    import lms_spi_pkg::*;
#(
    parameter logic [DATABITS-1:0] TX_DEFAULT  = 8'hFF,
    parameter int unsigned         SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                SCLK,
    input  logic                SS_n,
    input  logic                MOSI,
    output logic                MISO,
    output logic                MISO_oe,
    input  logic [ADDRBITS-1:0] mem_addr,
    input  logic [BUSBITS-1:0]  data_from_cpu,
    input  logic                read_n,
    input  logic                write_n,
    input  logic                spi_select,
    output logic [BUSBITS-1:0]  data_to_cpu,
    output logic                irq,
    output logic                dataavailable,
    output logic                readyfordata
);

    spi_state_t state, state_nxt;

    logic sclk_rise_c, sclk_fall_c, ss_rise_c, ss_fall_c;
    logic [SYNC_STAGES-1:0] mosi_chain;
    logic mosi_s;

    logic [DATABITS-1:0] shift_tx, shift_rx, tx_holding, rx_holding, rx_byte_c;
    logic [CNTBITS-1:0]  bitcnt;
    logic byte_done, underrun_pend;
    logic tx_primed, rrdy, toe, roe, eop;
    logic [BUSBITS-1:0] ctrl, status_c, rdata_c, eop_rd_c;
    logic rd_q, wr_q, rd_start_c, wr_start_c, rx_read_c;
    logic byte_start_c, shift_c, rx_bit_c, abort_c, byte_end_c;

    lms_spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .reset_n(reset_n), .async_in(SCLK), .rise_c(sclk_rise_c), .fall_c(sclk_fall_c)
    );

    lms_spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
        .clk(clk), .reset_n(reset_n), .async_in(SS_n), .rise_c(ss_rise_c), .fall_c(ss_fall_c)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) mosi_chain <= '0;
        else          mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], MOSI};
    end
    assign mosi_s = mosi_chain[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Frame sequencing: decode synced pin edges into shifter actions
    always_comb begin
        state_nxt    = state;
        byte_start_c = 1'b0;
        shift_c      = 1'b0;
        rx_bit_c     = 1'b0;
        abort_c      = 1'b0;
        case (state)
            S_IDLE: begin
                if (ss_fall_c) begin
                    state_nxt    = S_ACTIVE;
                    byte_start_c = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (ss_rise_c) begin
                    state_nxt = S_IDLE;
                    abort_c   = 1'b1;
                end else begin
                    rx_bit_c = sclk_rise_c;
                    if (sclk_fall_c) begin
                        byte_start_c = byte_done;
                        shift_c      = ~byte_done;
                    end
                end
            end
        endcase
    end

    assign rx_byte_c  = {shift_rx[DATABITS-2:0], mosi_s};
    assign byte_end_c = rx_bit_c & (bitcnt == CNTBITS'(DATABITS - 1));

    // Shifters and bit counter; an underrun after a completed byte only counts once the
    // master actually clocks the next byte
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_tx      <= TX_DEFAULT;
            shift_rx      <= '0;
            rx_holding    <= '0;
            bitcnt        <= '0;
            byte_done     <= 1'b0;
            underrun_pend <= 1'b0;
        end else begin
            if (byte_start_c)  shift_tx <= tx_primed ? tx_holding : TX_DEFAULT;
            else if (shift_c)  shift_tx <= {shift_tx[DATABITS-2:0], 1'b0};
            if (abort_c) begin
                bitcnt        <= '0;
                byte_done     <= 1'b0;
                underrun_pend <= 1'b0;
            end else begin
                if (rx_bit_c) begin
                    shift_rx      <= rx_byte_c;
                    bitcnt        <= bitcnt + CNTBITS'(1);
                    underrun_pend <= 1'b0;
                end
                if (byte_end_c) begin
                    rx_holding <= rx_byte_c;
                    byte_done  <= 1'b1;
                end else if (byte_start_c) begin
                    byte_done <= 1'b0;
                end
                if (byte_start_c && (state == S_ACTIVE) && !tx_primed) underrun_pend <= 1'b1;
            end
        end
    end

    assign rd_start_c = spi_select & ~read_n & ~rd_q;
    assign wr_start_c = spi_select & ~write_n & ~wr_q;
    assign rx_read_c  = rd_start_c & (mem_addr == REG_RXDATA);

    always_comb begin
        status_c            = '0;
        status_c[STAT_EOP]  = eop;
        status_c[STAT_E]    = toe | roe;
        status_c[STAT_RRDY] = rrdy;
        status_c[STAT_TRDY] = ~tx_primed;
        status_c[STAT_TMT]  = (state == S_IDLE) & ~tx_primed;
        status_c[STAT_TOE]  = toe;
        status_c[STAT_ROE]  = roe;
    end

    always_comb begin
        case (mem_addr)
            REG_RXDATA:  rdata_c = BUSBITS'(rx_holding);
            REG_STATUS:  rdata_c = status_c;
            REG_CONTROL: rdata_c = ctrl;
            REG_EOP:     rdata_c = eop_rd_c;
            default:     rdata_c = '0;
        endcase
    end

    // CPU port, holding registers and status flags; flag sets take priority over clears
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            data_to_cpu <= '0;
            tx_holding  <= '0;
            tx_primed   <= 1'b0;
            rrdy        <= 1'b0;
            toe         <= 1'b0;
            roe         <= 1'b0;
            ctrl        <= '0;
            irq         <= 1'b0;
        end else begin
            rd_q <= spi_select & ~read_n;
            wr_q <= spi_select & ~write_n;
            if (rd_start_c) data_to_cpu <= rdata_c;
            if (wr_start_c && (mem_addr == REG_CONTROL)) ctrl <= data_from_cpu & CTRL_MASK;
            if (wr_start_c && (mem_addr == REG_STATUS)) begin
                rrdy <= 1'b0;
                toe  <= 1'b0;
                roe  <= 1'b0;
            end
            if (rx_read_c) rrdy <= 1'b0;
            if (byte_start_c) begin
                tx_primed <= 1'b0;
                if (!tx_primed && (state == S_IDLE)) toe <= 1'b1;
            end
            if (rx_bit_c && underrun_pend) toe <= 1'b1;
            if (wr_start_c && (mem_addr == REG_TXDATA)) begin
                if (!tx_primed) begin
                    tx_holding <= data_from_cpu[DATABITS-1:0];
                    tx_primed  <= 1'b1;
                end else begin
                    toe <= 1'b1;
                end
            end
            if (byte_end_c) begin
                rrdy <= 1'b1;
                if (rrdy && !rx_read_c) roe <= 1'b1;
            end
            irq <= |(status_c & ctrl);
        end
    end

`ifdef LMS_SPI_SLAVE_EOP_EN
    logic [BUSBITS-1:0] eop_value;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            eop_value <= '0;
            eop       <= 1'b0;
        end else begin
            if (wr_start_c && (mem_addr == REG_EOP)) eop_value <= data_from_cpu;
            if (wr_start_c && (mem_addr == REG_STATUS)) eop <= 1'b0;
            if ((rx_read_c && (rx_holding == eop_value[DATABITS-1:0])) ||
                (wr_start_c && (mem_addr == REG_TXDATA) &&
                 (data_from_cpu[DATABITS-1:0] == eop_value[DATABITS-1:0])))
                eop <= 1'b1;
        end
    end
    assign eop_rd_c = eop_value;
`else
    assign eop      = 1'b0;
    assign eop_rd_c = '0;
`endif

    assign MISO          = shift_tx[DATABITS-1];
    assign MISO_oe       = (state == S_ACTIVE);
    assign dataavailable = rrdy;
    assign readyfordata  = ~tx_primed;

endmodule

// File: tb/tb_lms_ctr_fpga_spi_slave.sv
// Bench for lms_ctr_fpga_spi_slave: expected MISO bytes queued per frame, compared per byte.
`timescale 1ns/1ps
module tb_lms_ctr_fpga_spi_slave;

    logic        clk = 1'b0;
    logic        reset_n, SCLK, SS_n, MOSI, MISO, MISO_oe;
    logic [2:0]  mem_addr;
    logic [15:0] data_from_cpu, data_to_cpu;
    logic        read_n, write_n, spi_select, irq, dataavailable, readyfordata;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_miso_q[$];
    logic [15:0] exp_eop_value;
    logic [15:0] exp_eop_bit;

    lms_ctr_fpga_spi_slave dut (
        .clk(clk), .reset_n(reset_n), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI),
        .MISO(MISO), .MISO_oe(MISO_oe), .mem_addr(mem_addr), .data_from_cpu(data_from_cpu),
        .read_n(read_n), .write_n(write_n), .spi_select(spi_select),
        .data_to_cpu(data_to_cpu), .irq(irq), .dataavailable(dataavailable),
        .readyfordata(readyfordata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        spi_select = 1'b1; write_n = 1'b0; mem_addr = a; data_from_cpu = d;
        idle(2);
        spi_select = 1'b0; write_n = 1'b1;
        idle(1);
    endtask

    task automatic cpu_read(input logic [2:0] a, output logic [15:0] d);
        @(negedge clk);
        spi_select = 1'b1; read_n = 1'b0; mem_addr = a;
        idle(2);
        spi_select = 1'b0; read_n = 1'b1;
        d = data_to_cpu;
        idle(1);
    endtask

    task automatic reg_check(input string tag, input logic [2:0] a, input logic [15:0] exp);
        logic [15:0] d;
        cpu_read(a, d);
        check(tag, d, exp);
    endtask

    task automatic ss_set(input logic v);
        @(negedge clk);
        SS_n = v;
        idle(8);
    endtask

    // Mode-0 master: MOSI set while SCLK low, MISO sampled just before each rising edge
    task automatic spi_bits(input logic [7:0] b, input int nbits);
        logic [7:0] got;
        logic [7:0] exp;
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            MOSI = b[3'(7 - i)];
            idle(8);
            got[3'(7 - i)] = MISO;
            SCLK = 1'b1;
            idle(8);
            SCLK = 1'b0;
        end
        if (nbits == 8) begin
            exp = (exp_miso_q.size() > 0) ? exp_miso_q.pop_front() : 8'hxx;
            check("miso_byte", 16'(got), 16'(exp));
        end
    endtask

    initial begin
        reset_n = 1'b0; SCLK = 1'b0; SS_n = 1'b1; MOSI = 1'b0;
        mem_addr = '0; data_from_cpu = '0; read_n = 1'b1; write_n = 1'b1; spi_select = 1'b0;
`ifdef LMS_SPI_SLAVE_EOP_EN
        exp_eop_value = 16'h000D;
        exp_eop_bit   = 16'h0200;
`else
        exp_eop_value = 16'h0000;
        exp_eop_bit   = 16'h0000;
`endif
        idle(3);
        check("rst_miso", 16'(MISO), 16'd1);
        check("rst_oe", 16'(MISO_oe), 16'd0);
        check("rst_dout", data_to_cpu, 16'h0000);
        check("rst_irq", 16'(irq), 16'd0);
        check("rst_rrdy", 16'(dataavailable), 16'd0);
        check("rst_trdy", 16'(readyfordata), 16'd1);
        reset_n = 1'b1;
        idle(4);
        reg_check("rst_status", 3'd2, 16'h0060);
        reg_check("rst_ctrl", 3'd3, 16'h0000);

        // Primed TX byte, single-byte frame
        cpu_write(3'd1, 16'h00A5);
        check("t1_trdy", 16'(readyfordata), 16'd0);
        reg_check("t1_status_primed", 3'd2, 16'h0000);
        exp_miso_q.push_back(8'hA5);
        ss_set(1'b0);
        check("t1_oe_on", 16'(MISO_oe), 16'd1);
        spi_bits(8'h3C, 8);
        ss_set(1'b1);
        check("t1_oe_off", 16'(MISO_oe), 16'd0);
        reg_check("t1_status", 3'd2, 16'h00E0);
        check("t1_rrdy", 16'(dataavailable), 16'd1);
        reg_check("t1_rx", 3'd0, 16'h003C);
        reg_check("t1_status_rd", 3'd2, 16'h0060);
        check("t1_rrdy_clr", 16'(dataavailable), 16'd0);

        // Underrun with E interrupt enabled
        cpu_write(3'd3, 16'h0100);
        idle(2);
        check("t2_irq_off", 16'(irq), 16'd0);
        exp_miso_q.push_back(8'hFF);
        ss_set(1'b0);
        spi_bits(8'h55, 8);
        ss_set(1'b1);
        reg_check("t2_status", 3'd2, 16'h01F0);
        check("t2_irq_on", 16'(irq), 16'd1);
        reg_check("t2_rx", 3'd0, 16'h0055);
        cpu_write(3'd2, 16'h0000);
        idle(2);
        check("t2_irq_clr", 16'(irq), 16'd0);
        reg_check("t2_status_clr", 3'd2, 16'h0060);

        // Two bytes, never read: overrun
        exp_miso_q.push_back(8'hFF);
        exp_miso_q.push_back(8'hFF);
        ss_set(1'b0);
        spi_bits(8'h11, 8);
        spi_bits(8'h22, 8);
        ss_set(1'b1);
        reg_check("t3_status", 3'd2, 16'h01F8);
        check("t3_irq", 16'(irq), 16'd1);
        cpu_write(3'd2, 16'h0000);
        reg_check("t3_status_clr", 3'd2, 16'h0060);
        reg_check("t3_rx", 3'd0, 16'h0022);

        // Aborted partial byte then a full one
        ss_set(1'b0);
        spi_bits(8'hF0, 5);
        ss_set(1'b1);
        check("t4_no_rrdy", 16'(dataavailable), 16'd0);
        cpu_write(3'd2, 16'h0000);
        exp_miso_q.push_back(8'hFF);
        ss_set(1'b0);
        spi_bits(8'h81, 8);
        ss_set(1'b1);
        check("t4_rrdy", 16'(dataavailable), 16'd1);
        reg_check("t4_rx", 3'd0, 16'h0081);
        check("t4_rrdy_clr", 16'(dataavailable), 16'd0);
        cpu_write(3'd2, 16'h0000);

        // Second TX write dropped
        cpu_write(3'd1, 16'h00C3);
        cpu_write(3'd1, 16'h0099);
        reg_check("t5_status", 3'd2, 16'h0110);
        check("t5_trdy", 16'(readyfordata), 16'd0);
        exp_miso_q.push_back(8'hC3);
        ss_set(1'b0);
        spi_bits(8'h7E, 8);
        ss_set(1'b1);
        reg_check("t5_status_after", 3'd2, 16'h01F0);
        reg_check("t5_rx", 3'd0, 16'h007E);
        cpu_write(3'd2, 16'h0000);

        // EOP value register and detection on rx read
        cpu_write(3'd6, 16'h000D);
        reg_check("t6_eop_value", 3'd6, exp_eop_value);
        reg_check("t6_reg5", 3'd5, 16'h0000);
        exp_miso_q.push_back(8'hFF);
        ss_set(1'b0);
        spi_bits(8'h0D, 8);
        ss_set(1'b1);
        reg_check("t6_rx", 3'd0, 16'h000D);
        reg_check("t6_status", 3'd2, 16'h0170 | exp_eop_bit);
        check("t6_irq", 16'(irq), 16'd1);

        // Reset asserted in the middle of a byte
        ss_set(1'b0);
        spi_bits(8'hAA, 3);
        check("rst2_oe_before", 16'(MISO_oe), 16'd1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst2_miso", 16'(MISO), 16'd1);
        check("rst2_oe", 16'(MISO_oe), 16'd0);
        check("rst2_dout", data_to_cpu, 16'h0000);
        check("rst2_irq", 16'(irq), 16'd0);
        check("rst2_rrdy", 16'(dataavailable), 16'd0);
        SS_n = 1'b1;
        SCLK = 1'b0;
        idle(3);
        reset_n = 1'b1;
        idle(4);
        reg_check("rst2_status", 3'd2, 16'h0060);
        reg_check("rst2_ctrl", 3'd3, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
